shadow_dcache_arbiter: RTL and testbench



---
 rtl/shadow_dcache_arbiter.sv | 166 ++++++++++++++++
 tb/tb_shadow_dcache_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shadow_dcache_arbiter.sv
// Arbitrates one D-cache request port between the LSU and the shadow-register save engine.
// ShRU has priority; a burst limiter guarantees LSU progress; each transaction stays with one owner.
package shadow_dcache_arbiter_pkg;
    typedef struct packed {
        logic [11:0] address_index;
        logic [43:0] address_tag;
        logic [63:0] data_wdata;
        logic        data_req;
        logic        data_we;
        logic [7:0]  data_be;
        logic [1:0]  data_size;
        logic [3:0]  data_id;
        logic        kill_req;
        logic        tag_valid;
    } dcache_req_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [3:0]  data_rid;
        logic [63:0] data_rdata;
    } dcache_rsp_t;
endpackage

module shadow_dcache_arbiter #(
    parameter int unsigned CVA6Cfg        = 0,
    parameter type         dcache_req_i_t = shadow_dcache_arbiter_pkg::dcache_req_t,
    parameter type         dcache_req_o_t = shadow_dcache_arbiter_pkg::dcache_rsp_t,
    parameter int unsigned MAX_SHRU_BURST = 4,
    parameter int unsigned CNT_WIDTH      = $clog2(MAX_SHRU_BURST + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  dcache_req_i_t lsu_req_i,
    output dcache_req_o_t lsu_rsp_o,
    input  dcache_req_i_t shru_req_i,
    output dcache_req_o_t shru_rsp_o,
    output dcache_req_i_t dcache_req_o,
    input  dcache_req_o_t dcache_req_i,
    output logic [1:0]    owner_o,
    output logic          lsu_starved_o
);

    typedef enum logic [2:0] {
        IDLE,
        HOLD_LSU,
        HOLD_SHRU,
        LSU_TAG,
        LSU_RESP
    } state_e;

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic          lsu_win;
    logic          shru_win;
    logic          lsu_gnt;
    logic          shru_gnt;
    logic          read_pending;
    logic [1:0]    owner_sel;
    dcache_req_i_t fwd_req;
    dcache_req_o_t lsu_rsp;
    dcache_req_o_t shru_rsp;

    assign lsu_starved_o = (cnt_q == CNT_WIDTH'(MAX_SHRU_BURST));
    assign read_pending  = (state_q == LSU_TAG) || (state_q == LSU_RESP);

    // Arbitration looks only at requests, state and the burst counter, never at gnt.
    always_comb begin
        lsu_win  = 1'b0;
        shru_win = 1'b0;
        case (state_q)
            IDLE: begin
                shru_win = shru_req_i.data_req && (!lsu_starved_o || !lsu_req_i.data_req);
                lsu_win  = !shru_win && lsu_req_i.data_req;
            end
            HOLD_LSU:  lsu_win  = 1'b1;
            HOLD_SHRU: shru_win = 1'b1;
            default: begin
                lsu_win  = 1'b0;
                shru_win = 1'b0;
            end
        endcase
        lsu_gnt  = lsu_win && lsu_req_i.data_req && dcache_req_i.data_gnt;
        shru_gnt = shru_win && shru_req_i.data_req && dcache_req_i.data_gnt;
    end

    always_comb begin
        fwd_req   = '0;
        owner_sel = 2'd0;
        if (shru_win) begin
            fwd_req   = shru_req_i;
            owner_sel = 2'd2;
        end else if (lsu_win) begin
            fwd_req   = lsu_req_i;
            owner_sel = 2'd1;
        end else if (read_pending) begin
            owner_sel = 2'd1;
        end
        // The tag phase carries only the late tag fields; data_req stays low.
        if (state_q == LSU_TAG) begin
            fwd_req.tag_valid   = lsu_req_i.tag_valid;
            fwd_req.kill_req    = lsu_req_i.kill_req;
            fwd_req.address_tag = lsu_req_i.address_tag;
        end

        lsu_rsp              = '0;
        shru_rsp             = '0;
        lsu_rsp.data_rdata   = dcache_req_i.data_rdata;
        lsu_rsp.data_rid     = dcache_req_i.data_rid;
        shru_rsp.data_rdata  = dcache_req_i.data_rdata;
        shru_rsp.data_rid    = dcache_req_i.data_rid;
        lsu_rsp.data_gnt     = lsu_gnt;
        shru_rsp.data_gnt    = shru_gnt;
        // Only an outstanding LSU read may accept rvalid; stray responses are dropped.
        lsu_rsp.data_rvalid  = read_pending && dcache_req_i.data_rvalid;
        shru_rsp.data_rvalid = 1'b0;

        dcache_req_o = fwd_req;
        lsu_rsp_o    = lsu_rsp;
        shru_rsp_o   = shru_rsp;
        owner_o      = owner_sel;
        if (!rst_ni) begin
            dcache_req_o = '0;
            lsu_rsp_o    = '0;
            shru_rsp_o   = '0;
            owner_o      = 2'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, HOLD_LSU, HOLD_SHRU: begin
                    if (lsu_gnt)
                        state_q <= lsu_req_i.data_we ? IDLE : LSU_TAG;
                    else if (shru_gnt)
                        state_q <= IDLE;
                    else if (lsu_win && lsu_req_i.data_req)
                        state_q <= HOLD_LSU;
                    else if (shru_win && shru_req_i.data_req)
                        state_q <= HOLD_SHRU;
                    else
                        state_q <= IDLE;
                end
                LSU_TAG:  state_q <= dcache_req_i.data_rvalid ? IDLE : LSU_RESP;
                LSU_RESP: if (dcache_req_i.data_rvalid) state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase

            if (!lsu_req_i.data_req || lsu_gnt)
                cnt_q <= '0;
            else if (shru_gnt && !lsu_starved_o)
                cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    a_hold_lsu_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == HOLD_LSU) |-> lsu_req_i.data_req);
    a_hold_shru_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == HOLD_SHRU) |-> shru_req_i.data_req);

endmodule

// File: tb/tb_shadow_dcache_arbiter.sv
// Directed bench for shadow_dcache_arbiter: priority, burst limiting, atomic loads,
// stall hold, reset mid-hold and response isolation, against hand-computed values.
module tb_shadow_dcache_arbiter;
    import shadow_dcache_arbiter_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    dcache_req_t lsu_req;
    dcache_req_t shru_req;
    dcache_req_t dc_req;
    dcache_rsp_t lsu_rsp;
    dcache_rsp_t shru_rsp;
    dcache_rsp_t cache_rsp;
    logic [1:0]  owner;
    logic        starved;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] exp_q[$];
    logic       exp_starve_q[$];

    always #5 clk_i = ~clk_i;

    shadow_dcache_arbiter #(.MAX_SHRU_BURST(4)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .lsu_req_i     (lsu_req),
        .lsu_rsp_o     (lsu_rsp),
        .shru_req_i    (shru_req),
        .shru_rsp_o    (shru_rsp),
        .dcache_req_o  (dc_req),
        .dcache_req_i  (cache_rsp),
        .owner_o       (owner),
        .lsu_starved_o (starved)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_lsu(input logic req, input logic we, input logic [43:0] tag);
        lsu_req             = '0;
        lsu_req.data_req    = req;
        lsu_req.data_we     = we;
        lsu_req.address_tag = tag;
        lsu_req.data_wdata  = {20'h0, tag};
        lsu_req.tag_valid   = 1'b1;
    endtask

    task automatic drive_shru(input logic req, input logic [43:0] tag, input logic [63:0] wdata);
        shru_req             = '0;
        shru_req.data_req    = req;
        shru_req.data_we     = 1'b1;
        shru_req.address_tag = tag;
        shru_req.data_wdata  = wdata;
        shru_req.data_be     = 8'hff;
    endtask

    task automatic drive_cache(input logic gnt, input logic rvalid, input logic [3:0] rid,
                               input logic [63:0] rdata);
        cache_rsp             = '0;
        cache_rsp.data_gnt    = gnt;
        cache_rsp.data_rvalid = rvalid;
        cache_rsp.data_rid    = rid;
        cache_rsp.data_rdata  = rdata;
    endtask

    initial begin
        logic [1:0] got_grant;
        int         shru_sent;

        rst_ni = 1'b0;
        drive_lsu(1'b0, 1'b0, 44'h0);
        drive_shru(1'b0, 44'h0, 64'h0);
        drive_cache(1'b0, 1'b0, 4'h0, 64'h0);
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("reset_owner", owner, 2'd0);
        check_eq("reset_req", dc_req.data_req, 1'b0);
        check_eq("reset_starved", starved, 1'b0);
        rst_ni = 1'b1;
        cyc();

        // Priority: both request in IDLE, ShRU wins
        drive_lsu(1'b1, 1'b0, 44'h111);
        drive_shru(1'b1, 44'h222, 64'hAAAA_0000_5555_1111);
        drive_cache(1'b1, 1'b0, 4'h0, 64'h0);
        #1;
        check_eq("prio_owner", owner, 2'd2);
        check_eq("prio_fwd_tag", dc_req.address_tag, 44'h222);
        check_eq("prio_shru_gnt", shru_rsp.data_gnt, 1'b1);
        check_eq("prio_lsu_gnt", lsu_rsp.data_gnt, 1'b0);
        cyc();
        shru_req.data_req = 1'b0;
        #1;
        check_eq("lsu_read_owner", owner, 2'd1);
        check_eq("lsu_read_gnt", lsu_rsp.data_gnt, 1'b1);
        check_eq("lsu_read_fwd_tag", dc_req.address_tag, 44'h111);
        cyc();
        // LSU_TAG
        lsu_req.data_req = 1'b0;
        drive_cache(1'b0, 1'b0, 4'h0, 64'h0);
        #1;
        check_eq("tag_req_low", dc_req.data_req, 1'b0);
        check_eq("tag_valid_fwd", dc_req.tag_valid, 1'b1);
        check_eq("tag_addr_fwd", dc_req.address_tag, 44'h111);
        cyc();
        // LSU_RESP: broadcast isolation
        check_eq("resp_req_low", dc_req.data_req, 1'b0);
        drive_cache(1'b0, 1'b1, 4'd3, 64'hDEAD_BEEF_0123_4567);
        #1;
        check_eq("iso_lsu_rvalid", lsu_rsp.data_rvalid, 1'b1);
        check_eq("iso_shru_rvalid", shru_rsp.data_rvalid, 1'b0);
        check_eq("iso_lsu_rid", lsu_rsp.data_rid, 4'd3);
        check_eq("iso_lsu_rdata", lsu_rsp.data_rdata, 64'hDEAD_BEEF_0123_4567);
        check_eq("iso_shru_rdata", shru_rsp.data_rdata, 64'hDEAD_BEEF_0123_4567);
        cyc();
        drive_cache(1'b0, 1'b0, 4'h0, 64'h0);
        #1;
        check_eq("back_idle_owner", owner, 2'd0);

        // Stall hold: ShRU stalled three cycles while LSU waits
        drive_lsu(1'b1, 1'b1, 44'h333);
        drive_shru(1'b1, 44'h444, 64'h4444_4444_0000_0044);
        for (int i = 0; i < 3; i++) begin
            lsu_req.address_tag = 44'h330 + 44'(i);
            #1;
            check_eq("hold_fwd_tag", dc_req.address_tag, 44'h444);
            check_eq("hold_fwd_wdata", dc_req.data_wdata, 64'h4444_4444_0000_0044);
            check_eq("hold_owner", owner, 2'd2);
            cyc();
        end
        cache_rsp.data_gnt = 1'b1;
        #1;
        check_eq("hold_release_gnt", shru_rsp.data_gnt, 1'b1);
        check_eq("hold_release_lsu", lsu_rsp.data_gnt, 1'b0);
        cyc();
        shru_req.data_req = 1'b0;
        #1;
        check_eq("after_hold_lsu_gnt", lsu_rsp.data_gnt, 1'b1);
        cyc();
        drive_lsu(1'b0, 1'b0, 44'h0);
        drive_cache(1'b0, 1'b0, 4'h0, 64'h0);
        cyc();

        // Reset mid-HOLD_SHRU
        drive_shru(1'b1, 44'h999, 64'h9);
        cyc();
        check_eq("pre_reset_owner", owner, 2'd2);
        rst_ni = 1'b0;
        #1;
        check_eq("in_reset_owner", owner, 2'd0);
        check_eq("in_reset_req", dc_req.data_req, 1'b0);
        cyc();
        check_eq("reset_edge_owner", owner, 2'd0);
        check_eq("reset_edge_req", dc_req.data_req, 1'b0);
        shru_req.data_req = 1'b0;
        drive_cache(1'b0, 1'b1, 4'd5, 64'h5);
        rst_ni = 1'b1;
        #1;
        check_eq("stale_rvalid_drop", lsu_rsp.data_rvalid, 1'b0);
        check_eq("post_reset_owner", owner, 2'd0);
        cyc();
        drive_cache(1'b0, 1'b0, 4'h0, 64'h0);
        cyc();

        // Starvation: grant order S S S S L S S, starved high once
        exp_q        = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2};
        exp_starve_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        drive_lsu(1'b1, 1'b1, 44'h555);
        drive_shru(1'b0, 44'h600, 64'h6);
        drive_cache(1'b1, 1'b0, 4'h0, 64'h0);
        shru_sent = 0;
        for (int i = 0; i < 7; i++) begin
            shru_req.data_req    = (shru_sent < 6);
            shru_req.address_tag = 44'h600 + 44'(i);
            #1;
            got_grant = shru_rsp.data_gnt ? 2'd2 : (lsu_rsp.data_gnt ? 2'd1 : 2'd0);
            check_eq("starve_grant_order", got_grant, exp_q.pop_front());
            check_eq("starve_flag", starved, exp_starve_q.pop_front());
            if (shru_rsp.data_gnt) shru_sent++;
            cyc();
        end
        drive_lsu(1'b0, 1'b0, 44'h0);
        drive_shru(1'b0, 44'h0, 64'h0);
        cyc();
        check_eq("starve_cleared", starved, 1'b0);

        // Atomic load: ShRU held off until the LSU read completes
        drive_lsu(1'b1, 1'b0, 44'h777);
        drive_cache(1'b1, 1'b0, 4'h0, 64'h0);
        #1;
        check_eq("atom_c0_gnt", lsu_rsp.data_gnt, 1'b1);
        cyc();
        drive_shru(1'b1, 44'h888, 64'h8888);
        #1;
        check_eq("atom_c1_req", dc_req.data_req, 1'b0);
        check_eq("atom_c1_tag_valid", dc_req.tag_valid, 1'b1);
        check_eq("atom_c1_tag", dc_req.address_tag, 44'h777);
        check_eq("atom_c1_shru_gnt", shru_rsp.data_gnt, 1'b0);
        lsu_req.data_req = 1'b0;
        for (int c = 2; c < 4; c++) begin
            cyc();
            check_eq("atom_wait_req", dc_req.data_req, 1'b0);
            check_eq("atom_wait_owner", owner, 2'd1);
        end
        cyc();
        cache_rsp.data_rvalid = 1'b1;
        cache_rsp.data_rdata  = 64'h1234;
        #1;
        check_eq("atom_c4_rvalid", lsu_rsp.data_rvalid, 1'b1);
        check_eq("atom_c4_shru_gnt", shru_rsp.data_gnt, 1'b0);
        cyc();
        cache_rsp.data_rvalid = 1'b0;
        #1;
        check_eq("atom_c5_owner", owner, 2'd2);
        check_eq("atom_c5_tag", dc_req.address_tag, 44'h888);
        check_eq("atom_c5_shru_gnt", shru_rsp.data_gnt, 1'b1);
        cyc();
        drive_shru(1'b0, 44'h0, 64'h0);

        // Killed load with rvalid already in the tag cycle
        drive_lsu(1'b1, 1'b0, 44'hABC);
        drive_cache(1'b1, 1'b0, 4'h0, 64'h0);
        cyc();
        lsu_req.data_req = 1'b0;
        lsu_req.kill_req = 1'b1;
        drive_cache(1'b0, 1'b1, 4'd1, 64'h0);
        #1;
        check_eq("kill_fwd", dc_req.kill_req, 1'b1);
        check_eq("kill_rvalid", lsu_rsp.data_rvalid, 1'b1);
        cyc();
        drive_cache(1'b0, 1'b0, 4'h0, 64'h0);
        drive_lsu(1'b0, 1'b0, 44'h0);
        #1;
        check_eq("kill_idle_owner", owner, 2'd0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
